sub32_serial: RTL and testbench

Multi-cycle 32-bit subtractor: the inverse of the team's 32-bit adder. It accepts a sum word, one operand and a borrow-in, and returns the other operand plus a borrow-out. Arithmetic runs digit-serially, DIGIT bits per clock, so one narrow subtract slice is reused across the word. Valid/ready handshakes on both sides let it sit between the adder-test stimulus and a result checker, recovering `a` from `{sum, b}`.

---
 rtl/sub32_serial.sv | 94 +++++++++
 tb/tb_sub32_serial.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sub32_serial.sv
// Digit-serial subtractor: diff = (sum - b - bIn) mod 2^WIDTH, DIGIT bits per clock,
// with valid/ready handshakes on input and output and a single-operation pipeline.
module sub32_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bOut
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sum_q, sum_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              brw_q, brw_d, bout_q, bout_d;
  logic [DIGIT-1:0]  s_dig, b_dig;
  logic [DIGIT:0]    slice;

  // One DIGIT+1 bit slice is reused for every digit; its MSB is the outgoing borrow.
  always_comb begin
    s_dig = sum_q[idx_q*DIGIT +: DIGIT];
    b_dig = b_q[idx_q*DIGIT +: DIGIT];
    slice = {1'b0, s_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    b_d     = b_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        sum_d   = sum;
        b_d     = b;
        brw_d   = bIn;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d[idx_q*DIGIT +: DIGIT] = slice[DIGIT-1:0];
        brw_d = slice[DIGIT];
        idx_d = idx_q + 1'b1;
        if (idx_q == CW'(NDIG - 1)) begin
          bout_d  = slice[DIGIT];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake flags decode the state register only; data outputs are registers.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bOut      = bout_q;
endmodule

// File: tb/tb_sub32_serial.sv
// Directed bench for sub32_serial: hand-computed results, latency, backpressure,
// back-to-back spacing and asynchronous reset mid-operation.
module tb_sub32_serial;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sum = '0;
  logic [31:0] b = '0;
  logic        bIn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        bOut;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  sub32_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .b(b), .bIn(bIn), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bOut(bOut)
  );

  always #5 clock = ~clock;

  // Drives one operation and returns the result seen when out_valid first rises.
  task automatic do_op(input logic [31:0] s, input logic [31:0] bb, input logic bi,
                       output logic [31:0] d, output logic bo, output int lat,
                       output logic rdy_low);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clock); #1; w++;
    end
    sum = s; b = bb; bIn = bi; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; sum = 32'hDEADBEEF; b = 32'hCAFEF00D; bIn = 1'b1;
    rdy_low = 1'b1;
    lat = -1;
    d = 'x; bo = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (in_ready) rdy_low = 1'b0;
      if (out_valid) begin
        lat = c - 1; d = diff; bo = bOut;
        break;
      end
      @(posedge clock); #1;
    end
    if (lat == -1) begin
      lat = 0;
      for (int c = 0; c < 1; c++) ;
    end
  endtask

  logic [31:0] d;
  logic        bo;
  int          lat;
  logic        rl;

  task automatic test_reset();
    #3;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
    tot_cnt++; if (diff !== 32'h0) $display("FAIL rst_diff got %h exp 00000000", diff); else pass_cnt++;
    tot_cnt++; if (bOut !== 1'b0) $display("FAIL rst_bOut got %b exp 0", bOut); else pass_cnt++;
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_roundtrip();
    out_ready = 1'b1;
    do_op(32'h3, 32'h2, 1'b0, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'h1) $display("FAIL rt_diff got %h exp 00000001", d); else pass_cnt++;
    tot_cnt++; if (bo !== 1'b0) $display("FAIL rt_bOut got %b exp 0", bo); else pass_cnt++;
    tot_cnt++; if (lat !== 8) $display("FAIL rt_latency got %0d exp 8", lat); else pass_cnt++;
    tot_cnt++; if (rl !== 1'b1) $display("FAIL rt_in_ready_low got %b exp 1", rl); else pass_cnt++;
    @(posedge clock); #1;
    tot_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rt_return_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_underflow();
    do_op(32'h1, 32'h2, 1'b0, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL uf_diff got %h exp ffffffff", d); else pass_cnt++;
    tot_cnt++; if (bo !== 1'b1) $display("FAIL uf_bOut got %b exp 1", bo); else pass_cnt++;
  endtask

  task automatic test_boundary();
    do_op(32'h0, 32'h0, 1'b1, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL bin_diff got %h exp ffffffff", d); else pass_cnt++;
    tot_cnt++; if (bo !== 1'b1) $display("FAIL bin_bOut got %b exp 1", bo); else pass_cnt++;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL full_diff got %h exp ffffffff", d); else pass_cnt++;
    tot_cnt++; if (bo !== 1'b1) $display("FAIL full_bOut got %b exp 1", bo); else pass_cnt++;
    do_op(32'h80000000, 32'h1, 1'b0, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'h7FFFFFFF) $display("FAIL ripple_diff got %h exp 7fffffff", d); else pass_cnt++;
    tot_cnt++; if (bo !== 1'b0) $display("FAIL ripple_bOut got %b exp 0", bo); else pass_cnt++;
    do_op(32'h00000010, 32'h00000001, 1'b1, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'h0000000E) $display("FAIL mixed_diff got %h exp 0000000e", d); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    @(posedge clock); #1;
    out_ready = 1'b0;
    do_op(32'h12345678, 32'h11111111, 1'b0, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'h01234567) $display("FAIL bp_diff got %h exp 01234567", d); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; sum = 32'h0000FFFF; b = 32'h1; bIn = 1'b0;
      @(posedge clock); #1;
      tot_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'h01234567 || bOut !== 1'b0)
        $display("FAIL bp_hold cycle %0d got v=%b r=%b diff=%h bo=%b exp v=1 r=0 diff=01234567 bo=0",
                 c, out_valid, in_ready, diff, bOut);
      else pass_cnt++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    tot_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
    tot_cnt++; if (diff !== 32'h01234567) $display("FAIL bp_idle_keep got %h exp 01234567", diff); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc[2];
    logic [31:0] res[2];
    int na, nr, e;
    logic prev_rdy;
    na = 0; nr = 0; e = 0;
    out_ready = 1'b1;
    sum = 32'h5; b = 32'h2; bIn = 1'b0; in_valid = 1'b1;
    prev_rdy = in_ready;
    for (int c = 0; c < 40 && nr < 2; c++) begin
      @(posedge clock); e++;
      if (prev_rdy && in_valid && na < 2) begin
        acc[na] = e; na++;
      end
      #1;
      if (na == 1) begin sum = 32'h9; b = 32'h4; end
      if (na == 2) in_valid = 1'b0;
      if (out_valid && nr < 2) begin res[nr] = diff; nr++; end
      prev_rdy = in_ready;
    end
    in_valid = 1'b0;
    tot_cnt++; if (na !== 2 || acc[1] - acc[0] !== 10)
      $display("FAIL b2b_spacing got accepts=%0d gap=%0d exp accepts=2 gap=10", na, (na == 2) ? acc[1] - acc[0] : -1);
    else pass_cnt++;
    tot_cnt++; if (nr !== 2 || res[0] !== 32'h3 || res[1] !== 32'h5)
      $display("FAIL b2b_results got n=%0d r0=%h r1=%h exp n=2 r0=00000003 r1=00000005", nr, res[0], res[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1;
    sum = 32'hFFFF0000; b = 32'h1; bIn = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    tot_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_flags got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
    tot_cnt++; if (diff !== 32'h0 || bOut !== 1'b0)
      $display("FAIL midrst_data got diff=%h bo=%b exp diff=00000000 bo=0", diff, bOut); else pass_cnt++;
    @(negedge clock); reset_n = 1'b1;
    do_op(32'hA, 32'h3, 1'b0, d, bo, lat, rl);
    tot_cnt++; if (d !== 32'h7 || bo !== 1'b0)
      $display("FAIL midrst_fresh got diff=%h bo=%b exp diff=00000007 bo=0", d, bo); else pass_cnt++;
    tot_cnt++; if (lat !== 8) $display("FAIL midrst_latency got %0d exp 8", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_roundtrip();
    test_underflow();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
